// File: rtl/counter_pkg.sv
// Shared types for the counter family.
// Selects roll-over or clamp behaviour at the count bounds.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP,
        CNT_SAT
    } cnt_mode_t;

endpackage

// File: rtl/counter_updown.sv
// Parametrised up/down counter with load, wrap/saturate and flags.
// Bounds are compared before stepping so any modulus works.
module counter_updown
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
    parameter int unsigned RESET_VAL = 0,
    parameter cnt_mode_t   MODE      = CNT_WRAP
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             event_o,
    output logic             at_max_o,
    output logic             at_zero_o
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_C  = '0;

    if (MAX_VAL > (2**WIDTH) - 1) begin : g_bad_max
        $error("MAX_VAL must fit in WIDTH bits");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_rst
        $error("RESET_VAL must not exceed MAX_VAL");
    end

    logic [WIDTH-1:0] data_q, data_d;
    logic             event_q, event_d;
    logic             at_max_q, at_max_d;
    logic             at_zero_q, at_zero_d;

    // Next count and event: load beats enable, bounds checked before stepping.
    always_comb begin
        data_d  = data_q;
        event_d = 1'b0;
        if (load_i) begin
            data_d = (load_data_i > MAX_C) ? MAX_C : load_data_i;
        end else if (enable_i) begin
            if (up_i) begin
                if (data_q == MAX_C) begin
                    event_d = 1'b1;
                    data_d  = (MODE == CNT_SAT) ? MAX_C : ZERO_C;
                end else begin
                    data_d = data_q + ONE_C;
                end
            end else begin
                if (data_q == ZERO_C) begin
                    event_d = 1'b1;
                    data_d  = (MODE == CNT_SAT) ? ZERO_C : MAX_C;
                end else begin
                    data_d = data_q - ONE_C;
                end
            end
        end
        at_max_d  = (data_d == MAX_C);
        at_zero_d = (data_d == ZERO_C);
    end

    // Register stage; reset path ignores every other input.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            data_q    <= RESET_C;
            event_q   <= 1'b0;
            at_max_q  <= (RESET_C == MAX_C);
            at_zero_q <= (RESET_C == ZERO_C);
        end else begin
            data_q    <= data_d;
            event_q   <= event_d;
            at_max_q  <= at_max_d;
            at_zero_q <= at_zero_d;
        end
    end

    assign data_o    = data_q;
    assign event_o   = event_q;
    assign at_max_o  = at_max_q;
    assign at_zero_o = at_zero_q;

endmodule

// File: tb/tb_counter_updown.sv
// Bench: three counter configurations under shared stimulus.
// Per-cycle model comparison plus literal checkpoints.
module tb_counter_updown;
    import counter_pkg::*;

    localparam int MX[3]   = '{15, 9, 15};
    localparam int RV[3]   = '{0, 3, 0};
    localparam bit SATM[3] = '{1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       rst, en, up, ld;
    logic [3:0] ldd;

    logic [3:0] d0, d1, d2;
    logic       e0, e1, e2, mx0, mx1, mx2, z0, z1, z2;

    int n_chk  = 0;
    int n_fail = 0;

    int mv[3];
    bit mev[3];
    bit valid = 1'b0;

    always #5 clk = ~clk;

    counter_updown u0 (
        .clock_i(clk), .reset_i(rst), .enable_i(en), .up_i(up),
        .load_i(ld), .load_data_i(ldd), .data_o(d0), .event_o(e0),
        .at_max_o(mx0), .at_zero_o(z0)
    );

    counter_updown #(.MAX_VAL(9), .RESET_VAL(3)) u1 (
        .clock_i(clk), .reset_i(rst), .enable_i(en), .up_i(up),
        .load_i(ld), .load_data_i(ldd), .data_o(d1), .event_o(e1),
        .at_max_o(mx1), .at_zero_o(z1)
    );

    counter_updown #(.MODE(CNT_SAT)) u2 (
        .clock_i(clk), .reset_i(rst), .enable_i(en), .up_i(up),
        .load_i(ld), .load_data_i(ldd), .data_o(d2), .event_o(e2),
        .at_max_o(mx2), .at_zero_o(z2)
    );

    // Result packs the event in bit 16 above the next value.
    function automatic int step(int cur, int mx, bit sat, bit l,
                                int ldv, bit e, bit u);
        int nv;
        if (l) return (ldv > mx) ? mx : ldv;
        if (!e) return cur;
        nv = u ? cur + 1 : cur - 1;
        if (nv > mx) return (sat ? mx : 0) | 32'h1_0000;
        if (nv < 0) return (sat ? 0 : mx) | 32'h1_0000;
        return nv;
    endfunction

    // Reference model advances on each rising edge.
    always @(posedge clk) begin
        int r;
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                mv[i]  <= RV[i];
                mev[i] <= 1'b0;
            end else begin
                r = step(mv[i], MX[i], SATM[i], ld, int'(ldd), en, up);
                mv[i]  <= r & 32'hffff;
                mev[i] <= r[16];
            end
        end
        if (!rst) valid <= 1'b1;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(int i, logic [3:0] d, logic e, logic amx, logic az);
        logic [3:0] exp_d;
        exp_d = 4'(mv[i]);
        chk($sformatf("u%0d.data", i), {28'd0, d}, {28'd0, exp_d});
        chk($sformatf("u%0d.event", i), {31'd0, e}, {31'd0, mev[i]});
        chk($sformatf("u%0d.at_max", i), {31'd0, amx}, {31'd0, mv[i] == MX[i]});
        chk($sformatf("u%0d.at_zero", i), {31'd0, az}, {31'd0, mv[i] == 0});
    endtask

    // Every cycle once the model is seeded, away from the rising edge.
    always @(negedge clk) begin
        if (valid) begin
            cmp(0, d0, e0, mx0, z0);
            cmp(1, d1, e1, mx1, z1);
            cmp(2, d2, e2, mx2, z2);
        end
    end

    task automatic cyc(logic r, logic l, logic [3:0] v, logic e, logic u);
        rst = r;
        ld  = l;
        ldd = v;
        en  = e;
        up  = u;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int evc;
        logic [3:0] held;

        // Reset with unknown control inputs.
        repeat (3) cyc(1'b0, 1'bx, 4'bx, 1'bx, 1'bx);
        chk("rst.u0", {28'd0, d0}, 32'd0);
        chk("rst.u1", {28'd0, d1}, 32'd3);
        chk("rst.z0", {31'd0, z0}, 32'd1);
        chk("rst.mx0", {31'd0, mx0}, 32'd0);
        chk("rst.e0", {31'd0, e0}, 32'd0);

        // Free run up through the wrap.
        evc = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
            evc += int'(e0);
            if (k == 16) chk("t1.wrap_ev", {31'd0, e0}, 32'd1);
            if (k == 16) chk("t1.wrap_d", {28'd0, d0}, 32'd0);
        end
        chk("t1.final", {28'd0, d0}, 32'd4);
        chk("t1.evcount", 32'(evc), 32'd1);

        // Mod-10 down count from zero.
        cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("t2.d", {28'd0, d1}, 32'd9);
        chk("t2.ev", {31'd0, e1}, 32'd1);
        chk("t2.mx", {31'd0, mx1}, 32'd1);
        repeat (9) cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("t2.zero", {28'd0, d1}, 32'd0);
        chk("t2.zflag", {31'd0, z1}, 32'd1);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("t2.rewrap", {28'd0, d1}, 32'd9);

        // Saturate at the top, then step down.
        cyc(1'b1, 1'b1, 4'd13, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("t3.14", {28'd0, d2}, 32'd14);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("t3.15", {28'd0, d2}, 32'd15);
        chk("t3.ev0", {31'd0, e2}, 32'd0);
        repeat (2) begin
            cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
            chk("t3.hold", {28'd0, d2}, 32'd15);
            chk("t3.evhold", {31'd0, e2}, 32'd1);
        end
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        chk("t3.down", {28'd0, d2}, 32'd14);
        chk("t3.evdn", {31'd0, e2}, 32'd0);

        // Over-range load clamps; load beats enable.
        cyc(1'b1, 1'b1, 4'd12, 1'b1, 1'b1);
        chk("t4.clamp", {28'd0, d1}, 32'd9);
        chk("t4.mx", {31'd0, mx1}, 32'd1);
        chk("t4.ev", {31'd0, e1}, 32'd0);
        chk("t4.u0", {28'd0, d0}, 32'd12);

        // Reset mid-count beats load and enable.
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (7) cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("t5.seven", {28'd0, d0}, 32'd7);
        cyc(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
        chk("t5.u0", {28'd0, d0}, 32'd0);
        chk("t5.u1", {28'd0, d1}, 32'd3);
        chk("t5.ev", {31'd0, e0}, 32'd0);
        cyc(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("t5.res0", {28'd0, d0}, 32'd1);
        chk("t5.res1", {28'd0, d1}, 32'd4);

        // Disabled with direction toggling.
        held = d0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 4'd0, 1'b0, k[0]);
            chk("t6.hold", {28'd0, d0}, {28'd0, held});
            chk("t6.ev", {31'd0, e0}, 32'd0);
        end

        // Random traffic checked by the model every cycle.
        for (int k = 0; k < 600; k++) begin
            cyc(($urandom_range(0, 39) != 0),
                ($urandom_range(0, 9) == 0),
                4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 1) == 1));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
